// File: rtl/calc1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc1_pkg
//  Description : Shared command/response encodings, driver FSM state type and
//                command classification helper for the calc1 port drivers.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc1_pkg;

   // Command encodings understood by calc1 (zero-extended to 32 bits so they
   // can be compared against any configured command width)
   localparam logic [31:0] CMD_NOP = 32'd0;
   localparam logic [31:0] CMD_ADD = 32'd1;
   localparam logic [31:0] CMD_SUB = 32'd2;
   localparam logic [31:0] CMD_SHL = 32'd5;
   localparam logic [31:0] CMD_SHR = 32'd6;

   // Response codes on calc1's out_respN and on the driver's rsp_code
   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;
   localparam logic [1:0] RESP_TMO  = 2'd3;

   // Port driver sequencing states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_OPND = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // True for the commands calc1 actually implements
   function automatic logic is_valid_cmd(input logic [31:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
             (cmd == CMD_SHL) || (cmd == CMD_SHR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/calc1_port_driver.sv
`default_nettype none
// ============================================================================
//  Module      : calc1_port_driver
//  Description : Upstream request sequencer for one calc1 port. Takes a whole
//                operation in one valid/ready transfer, plays it out as the
//                two-cycle calc1 port protocol (cmd+op1, then 0+op2), waits
//                for the response (or a local timeout) and presents it on a
//                valid/ready result interface.
//                Optional macro CALC1_CMD_FILTER_EN: unsupported commands are
//                answered locally with an error and never reach calc1.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc1_port_driver
   import calc1_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int DATA_W         = 32,
   parameter int CMD_W          = 4
) (
   input  logic              c_clk,
   input  logic              reset_n,
   // upstream request
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CMD_W-1:0]  req_cmd,
   input  logic [DATA_W-1:0] req_op1,
   input  logic [DATA_W-1:0] req_op2,
   // calc1 port
   output logic [CMD_W-1:0]  calc_cmd_out,
   output logic [DATA_W-1:0] calc_data_out,
   input  logic [1:0]        calc_resp_in,
   input  logic [DATA_W-1:0] calc_data_in,
   // downstream result
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_code,
   output logic [DATA_W-1:0] rsp_data
);

   localparam logic [7:0] c_tmo_limit = 8'(TIMEOUT_CYCLES);

   state_t            r_state;
   logic              r_req_ready;
   logic [CMD_W-1:0]  r_calc_cmd;
   logic [DATA_W-1:0] r_calc_data;
   logic [DATA_W-1:0] r_op2;
   logic              r_rsp_valid;
   logic [1:0]        r_rsp_code;
   logic [DATA_W-1:0] r_rsp_data;
   logic [7:0]        r_cnt;

   logic              w_accept;
   logic              w_forward;
   logic [7:0]        w_cnt_nxt;

   assign w_accept  = req_valid && r_req_ready;
   assign w_cnt_nxt = r_cnt + 8'd1;

   // Decide whether an accepted command is sent to calc1 or answered locally
`ifdef CALC1_CMD_FILTER_EN
   assign w_forward = is_valid_cmd(32'(req_cmd));
`else
   assign w_forward = 1'b1;
`endif

   // Request sequencing FSM; every output comes straight from a register.
   // op1 goes onto the port on the accept edge, so only op2 needs holding.
   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_req_ready <= 1'b0;
         r_calc_cmd  <= '0;
         r_calc_data <= '0;
         r_op2       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_code  <= RESP_NONE;
         r_rsp_data  <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_req_ready <= 1'b1;
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_op2       <= req_op2;
                  if (w_forward) begin
                     r_calc_cmd  <= req_cmd;
                     r_calc_data <= req_op1;
                     r_state     <= ST_CMD;
                  end else begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_code  <= RESP_ERR;
                     r_rsp_data  <= '0;
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_CMD: begin
               r_calc_cmd  <= CMD_W'(CMD_NOP);
               r_calc_data <= r_op2;
               r_state     <= ST_OPND;
            end
            ST_OPND: begin
               r_calc_data <= '0;
               r_cnt       <= '0;
               r_state     <= ST_WAIT;
            end
            ST_WAIT: begin
               // A real response takes priority over an expiring timeout
               if (calc_resp_in != RESP_NONE) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_code  <= calc_resp_in;
                  r_rsp_data  <= (calc_resp_in == RESP_OK) ? calc_data_in : '0;
                  r_state     <= ST_DONE;
               end else if (w_cnt_nxt == c_tmo_limit) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_code  <= RESP_TMO;
                  r_rsp_data  <= '0;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_code  <= RESP_NONE;
                  r_rsp_data  <= '0;
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b0;
               r_calc_cmd  <= '0;
               r_calc_data <= '0;
               r_rsp_valid <= 1'b0;
               r_rsp_code  <= RESP_NONE;
               r_rsp_data  <= '0;
            end
         endcase
      end
   end

   assign req_ready     = r_req_ready;
   assign calc_cmd_out  = r_calc_cmd;
   assign calc_data_out = r_calc_data;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_code      = r_rsp_code;
   assign rsp_data      = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_calc1_port_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc1_port_driver
//  Description : Self-checking bench for calc1_port_driver. A transaction-level
//                model (calc1 arithmetic plus the driver's cycle timeline)
//                sets the expected outputs each cycle; one process compares.
//                Honours CALC1_CMD_FILTER_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc1_port_driver;

   localparam int TMO = 16;

`ifdef CALC1_CMD_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic        c_clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready;
   logic [3:0]  req_cmd;
   logic [31:0] req_op1, req_op2;
   logic [3:0]  calc_cmd_out;
   logic [31:0] calc_data_out;
   logic [1:0]  calc_resp_in;
   logic [31:0] calc_data_in;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_code;
   logic [31:0] rsp_data;

   calc1_port_driver #(.TIMEOUT_CYCLES(TMO), .DATA_W(32), .CMD_W(4)) dut (
      .c_clk(c_clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_op1(req_op1), .req_op2(req_op2),
      .calc_cmd_out(calc_cmd_out), .calc_data_out(calc_data_out),
      .calc_resp_in(calc_resp_in), .calc_data_in(calc_data_in),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_code(rsp_code), .rsp_data(rsp_data)
   );

   always #5 c_clk = ~c_clk;

   int total = 0;
   int bad   = 0;

   // expected outputs for the current cycle
   bit          chk_en = 1'b0;
   logic        e_rdy, e_val;
   logic [3:0]  e_cmd;
   logic [31:0] e_dat, e_rdat;
   logic [1:0]  e_code;

   // per-transaction observations from the DUT
   logic [1:0]  got_code;
   logic [31:0] got_data;
   int          dut_wait;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Single compare process: all outputs against the model every cycle
   always @(negedge c_clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(e_rdy));
         chk("calc_cmd",  32'(calc_cmd_out), 32'(e_cmd));
         chk("calc_data", calc_data_out, e_dat);
         chk("rsp_valid", 32'(rsp_valid), 32'(e_val));
         chk("rsp_code",  32'(rsp_code), 32'(e_code));
         chk("rsp_data",  rsp_data, e_rdat);
      end
   end

   // calc1 behaviour: what it answers for an operation (silent for cmd 0)
   task automatic calc_ref(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           output logic [1:0] code, output logic [31:0] res, output bit responds);
      longint s;
      responds = 1'b1;
      res      = 32'd0;
      code     = 2'd2;
      case (cmd)
         4'd0: begin responds = 1'b0; code = 2'd0; end
         4'd1: begin
            s = longint'(a) + longint'(b);
            if (s > 64'h0000_0000_FFFF_FFFF) code = 2'd2;
            else begin code = 2'd1; res = a + b; end
         end
         4'd2: if (a < b) code = 2'd2; else begin code = 2'd1; res = a - b; end
         4'd5: begin code = 2'd1; res = a << b[4:0]; end
         4'd6: begin code = 2'd1; res = a >> b[4:0]; end
         default: code = 2'd2;
      endcase
   endtask

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   task automatic set_idle_exp();
      e_rdy = 1'b1; e_cmd = 4'd0; e_dat = 32'd0;
      e_val = 1'b0; e_code = 2'd0; e_rdat = 32'd0;
   endtask

   // One whole operation; entered at posedge+1 with the DUT in IDLE, ready.
   // lat: WAIT cycle in which calc1 answers (>= TMO means never).
   task automatic do_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int rdy_wait, input int idle_pre);
      logic [1:0]  rc;
      logic [31:0] rr;
      bit          resp, fin;
      resp     = 1'b0;
      fin      = 1'b0;
      dut_wait = 0;
      for (int k = 0; k < idle_pre; k++) begin
         req_valid = 1'b0; req_cmd = 4'($urandom);
         calc_resp_in = 2'($urandom); rsp_ready = 1'($urandom);
         tick();
      end
      req_valid = 1'b1; req_cmd = cmd; req_op1 = a; req_op2 = b;
      calc_resp_in = 2'($urandom); calc_data_in = $urandom; rsp_ready = 1'($urandom);
      tick();
      req_valid = 1'($urandom); req_cmd = 4'($urandom); req_op1 = $urandom; req_op2 = $urandom;
      e_rdy = 1'b0;
      if (FILT && !(cmd inside {4'd1, 4'd2, 4'd5, 4'd6})) begin
         e_val = 1'b1; e_code = 2'd2; e_rdat = 32'd0;
      end else begin
         e_cmd = cmd; e_dat = a;                      // cmd cycle
         calc_resp_in = 2'($urandom);
         tick();
         e_cmd = 4'd0; e_dat = b;                     // operand cycle
         calc_resp_in = 2'($urandom);
         tick();
         e_dat = 32'd0;                               // waiting
         calc_ref(cmd, a, b, rc, rr, resp);
         for (int i = 0; i < TMO && !fin; i++) begin
            calc_resp_in = (resp && i == lat) ? rc : 2'd0;
            calc_data_in = (rc == 2'd1) ? rr : $urandom;
            rsp_ready    = 1'($urandom);
            req_valid    = 1'($urandom);
            tick();
            if (rsp_valid === 1'b1 && dut_wait == 0) dut_wait = i + 1;
            if (resp && i == lat) begin
               fin = 1'b1; e_val = 1'b1; e_code = rc; e_rdat = (rc == 2'd1) ? rr : 32'd0;
            end else if (i == TMO - 1) begin
               fin = 1'b1; e_val = 1'b1; e_code = 2'd3; e_rdat = 32'd0;
            end
         end
      end
      got_code = rsp_code;
      got_data = rsp_data;
      for (int k = 0; k < rdy_wait; k++) begin
         rsp_ready = 1'b0; req_valid = 1'($urandom);
         calc_resp_in = 2'($urandom); calc_data_in = $urandom;
         tick();
      end
      rsp_ready = 1'b1; req_valid = 1'b0; calc_resp_in = 2'($urandom);
      tick();
      set_idle_exp();
      rsp_ready = 1'($urandom);
   endtask

   initial begin
      logic [1:0]  mc;
      logic [31:0] mr;
      bit          mresp;
      logic [3:0]  cmds [8];
      cmds = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd15};

      reset_n = 1'b0; req_valid = 1'b0; req_cmd = 4'd0; req_op1 = 32'd0; req_op2 = 32'd0;
      calc_resp_in = 2'd0; calc_data_in = 32'd0; rsp_ready = 1'b0;
      set_idle_exp();

      // model pinned by hand-computed values
      calc_ref(4'd1, 32'd1, 32'h1FFF_FFFF, mc, mr, mresp);
      chk("ref_add", mr, 32'h2000_0000);
      calc_ref(4'd2, 32'd1, 32'hF, mc, mr, mresp);
      chk("ref_sub_err", 32'(mc), 32'd2);

      // reset state
      repeat (3) tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_calc_cmd", 32'(calc_cmd_out), 32'd0);
      chk("rst_calc_data", calc_data_out, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_code", 32'(rsp_code), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      #2 reset_n = 1'b1;
      tick();
      chk_en = 1'b1;

      // directed cases
      do_op(4'd1, 32'd1, 32'h1FFF_FFFF, 2, 0, 0);
      chk("add_code", 32'(got_code), 32'd1);
      chk("add_data", got_data, 32'h2000_0000);
      do_op(4'd1, 32'hFFFF_FFFF, 32'd1, 0, 1, 0);
      chk("ovf_code", 32'(got_code), 32'd2);
      chk("ovf_data", got_data, 32'd0);
      do_op(4'd2, 32'd1, 32'hF, 3, 0, 1);
      chk("udf_code", 32'(got_code), 32'd2);
      do_op(4'd5, 32'd1, 32'd1, 1, 10, 0);
      chk("shl_code", 32'(got_code), 32'd1);
      chk("shl_data", got_data, 32'd2);
      do_op(4'd1, 32'd5, 32'd6, 1000, 0, 0);
      chk("tmo_code", 32'(got_code), 32'd3);
      chk("tmo_len", 32'(dut_wait), 32'(TMO));
      do_op(4'd6, 32'h8000_0000, 32'd4, TMO - 1, 0, 0);
      chk("late_resp_code", 32'(got_code), 32'd1);
      chk("late_resp_data", got_data, 32'h0800_0000);
      do_op(4'd3, 32'd7, 32'd8, 2, 0, 0);
      chk("inv_code", 32'(got_code), 32'd2);

      // reset asserted while waiting for calc1
      req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'd3; req_op2 = 32'd4; calc_resp_in = 2'd0;
      tick();
      req_valid = 1'b0; e_rdy = 1'b0; e_cmd = 4'd1; e_dat = 32'd3;
      tick();
      e_cmd = 4'd0; e_dat = 32'd4;
      tick();
      e_dat = 32'd0;
      tick();
      tick();
      chk_en = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_req_ready", 32'(req_ready), 32'd0);
      chk("arst_calc_cmd", 32'(calc_cmd_out), 32'd0);
      chk("arst_calc_data", calc_data_out, 32'd0);
      chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("arst_rsp_code", 32'(rsp_code), 32'd0);
      chk("arst_rsp_data", rsp_data, 32'd0);
      tick();
      #2 reset_n = 1'b1;
      tick();
      set_idle_exp();
      chk_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         calc_resp_in = 2'($urandom); calc_data_in = $urandom; rsp_ready = 1'($urandom);
         tick();
      end
      do_op(4'd2, 32'd100, 32'd58, 0, 0, 0);
      chk("post_rst_code", 32'(got_code), 32'd1);
      chk("post_rst_data", got_data, 32'd42);

      // randomized operations
      for (int n = 0; n < 40; n++) begin
         do_op(cmds[$urandom_range(0, 7)], $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
               $urandom_range(0, 20), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
